// File: rtl/tqvp_seven_segment_encoder.sv
// tqvp_seven_segment_encoder
//   TinyQV peripheral that reads a 7-segment pattern on ui_in, debounces it,
//   encodes it back to a hex/BCD code and queues each newly accepted pattern
//   in a small FIFO that the CPU drains over the peripheral register bus.
//
// Ports
//   clk         project clock
//   rst         synchronous, active-high reset
//   ui_in       [6:0] segments g..a (bit0 = a), [7] ignored
//   uo_out      {nonempty, 3'b000, head code[3:0]}
//   address     register address
//   data_write  1-cycle write strobe
//   data_in     write data, valid with data_write
//   data_out    combinational read data for address
//
// Register map
//   0x0 R: FIFO head              W: pop
//   0x1 R: {nonempty, full, ovf, 2'b00, count[2:0]}  W: data_in[5] clears ovf
//   0x2 RW: {en, 5'b0, hex, al}
//   0x3 RW: debounce threshold (write also restarts the stability count)
//   0x4 R: {0, seg}
//   0x5 R: {0, last accepted pattern}

module tqvp_seven_segment_encoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] THR_RESET  = 8'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          en, hex, al, ovf;
  logic [7:0]    thr, cnt;
  logic [6:0]    samp, last;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [FIFO_DEPTH];

  logic [6:0] seg;
  logic [7:0] thr_eff, entry, head;
  logic       empty, full, accept, push, push_ok, pop, ovf_set;
  logic       wr_head, wr_stat, wr_ctrl, wr_thr;
  logic       unused_ui7;

  // Entry: [7]=unrecognised, [6]=blank, [5:4]=0, [3:0]=code
  function automatic logic [7:0] encode(input logic [6:0] p, input logic hx);
    logic [7:0] e;
    case (p)
      7'h3F:        e = 8'h00;
      7'h06:        e = 8'h01;
      7'h5B:        e = 8'h02;
      7'h4F:        e = 8'h03;
      7'h66:        e = 8'h04;
      7'h6D:        e = 8'h05;
      7'h7D:        e = 8'h06;
      7'h07, 7'h27: e = 8'h07;
      7'h7F:        e = 8'h08;
      7'h6F, 7'h67: e = 8'h09;
      // 7C is a tail-less 6 in decimal mode, lowercase b in hex mode
      7'h7C:        e = hx ? 8'h0B : 8'h06;
      7'h77:        e = hx ? 8'h0A : 8'h80;
      7'h39:        e = hx ? 8'h0C : 8'h80;
      7'h5E:        e = hx ? 8'h0D : 8'h80;
      7'h79:        e = hx ? 8'h0E : 8'h80;
      7'h71:        e = hx ? 8'h0F : 8'h80;
      7'h00:        e = 8'h40;
      default:      e = 8'h80;
    endcase
    return e;
  endfunction

  assign unused_ui7 = ui_in[7];
  assign seg        = ui_in[6:0] ^ {7{al}};
  assign thr_eff    = (thr == 8'd0) ? 8'd1 : thr;

  // Fires once per stable run, on the edge where cnt reaches the threshold
  assign accept  = en && (seg == samp) && (cnt == thr_eff - 8'd1);
  assign push    = accept && (samp != last);
  assign entry   = encode(samp, hex);

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  assign wr_head = data_write && (address == 4'h0);
  assign wr_stat = data_write && (address == 4'h1);
  assign wr_ctrl = data_write && (address == 4'h2);
  assign wr_thr  = data_write && (address == 4'h3);

  assign pop     = wr_head && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b1;
      hex    <= 1'b1;
      al     <= 1'b1;
      thr    <= THR_RESET;
      samp   <= 7'h00;
      cnt    <= 8'd0;
      last   <= 7'h00;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (!en) begin
        cnt <= 8'd0;
      end else if (seg != samp) begin
        samp <= seg;
        cnt  <= 8'd0;
      end else if (cnt < thr_eff) begin
        cnt <= cnt + 8'd1;
      end

      if (wr_thr) begin
        thr <= data_in;
        cnt <= 8'd0;
      end

      if (wr_ctrl) begin
        en  <= data_in[7];
        hex <= data_in[1];
        al  <= data_in[0];
      end

      if (push) last <= samp;

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (ovf_set)                  ovf <= 1'b1;
      else if (wr_stat && data_in[5]) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: head is gated by empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = head;
      4'h1:    data_out = {!empty, full, ovf, 2'b00, 3'(count)};
      4'h2:    data_out = {en, 5'b00000, hex, al};
      4'h3:    data_out = thr;
      4'h4:    data_out = {1'b0, seg};
      4'h5:    data_out = {1'b0, last};
      default: data_out = 8'h00;
    endcase
  end

  assign uo_out = {!empty, 3'b000, head[3:0]};

endmodule
